// File: rtl/pe_pkg.sv
// pe_pkg: shared modes, FSM states, bf16 unpack record and lane slicing helper
package pe_pkg;
  typedef enum logic [1:0] {MODE_MM = 2'b00, MODE_FPU = 2'b10} mode_e;
  typedef enum logic {S_IDLE = 1'b0, S_ACC = 1'b1} state_e;
  localparam logic [8:0] BF16_BIAS = 9'd127;
  localparam int FP_W = 20;
  typedef struct packed {
    logic [1:0] pad;
    logic [8:0] exp_unb;
    logic [8:0] man;
  } fp_unpack_t;
  function automatic int lane_lsb(input int lane, input int width);
    return lane * width;
  endfunction
endpackage

// File: rtl/delay_chain.sv
// delay_chain: DEPTH-stage register pipeline with synchronous flush
module delay_chain #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);
  logic [WIDTH-1:0] r_pipe [DEPTH];
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_pipe <= '{default: '0};
    else if (clr) r_pipe <= '{default: '0};
    else begin
      r_pipe[0] <= d;
      for (int i = 1; i < DEPTH; i++) r_pipe[i] <= r_pipe[i-1];
    end
  end
  assign q = r_pipe[DEPTH-1];
endmodule

// File: rtl/pe_lane.sv
// pe_lane: one lane - weight select, pipelined signed multiply, saturating accumulate, bf16 unpack
module pe_lane import pe_pkg::*; #(
  parameter int DATA_W  = 8,
  parameter int ACC_W   = 32,
  parameter int MUL_LAT = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr_in,
  input  logic              mm_in,
  input  logic              fp_in,
  input  logic              y_sel_in,
  input  logic [DATA_W-1:0] left_in,
  input  logic [15:0]       slot_in,
  input  logic              ex_v_in,
  input  logic              ex_last_in,
  output logic [ACC_W-1:0]  res_out,
  output logic              sat_out,
  output logic [FP_W-1:0]   fp_out
);
  localparam int P_W = 2 * DATA_W;
  logic [DATA_W-1:0] w_wt;
  logic [P_W-1:0]    w_prod, w_pexit;
  logic [ACC_W:0]    w_sum;
  logic              w_ovf;
  logic [ACC_W-1:0]  r_acc;
  fp_unpack_t        w_fp;
  logic [FP_W-1:0]   w_fp_bits;
  assign w_wt   = y_sel_in ? slot_in[2*DATA_W-1:DATA_W] : slot_in[DATA_W-1:0];
  assign w_prod = mm_in ? $signed({{DATA_W{left_in[DATA_W-1]}}, left_in}) *
                          $signed({{DATA_W{w_wt[DATA_W-1]}}, w_wt}) : '0;
  delay_chain #(.WIDTH(P_W), .DEPTH(MUL_LAT)) u_mul (
    .clk(clk), .rst_n(rst_n), .clr(clr_in), .d(w_prod), .q(w_pexit)
  );
  // one guard bit: overflow shows as disagreement between the top two sum bits
  assign w_sum   = {r_acc[ACC_W-1], r_acc} + {{(ACC_W + 1 - P_W){w_pexit[P_W-1]}}, w_pexit};
  assign w_ovf   = w_sum[ACC_W] ^ w_sum[ACC_W-1];
  assign res_out = w_ovf ? {w_sum[ACC_W], {(ACC_W-1){~w_sum[ACC_W]}}} : w_sum[ACC_W-1:0];
  assign sat_out = ex_v_in && w_ovf;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_acc <= '0;
    else if (clr_in) r_acc <= '0;
    else if (ex_v_in) r_acc <= ex_last_in ? '0 : res_out;
  end
  assign w_fp = '{
    pad:     2'b00,
    exp_unb: {1'b0, slot_in[14:7]} - BF16_BIAS,
    man:     slot_in[14:7] == 8'd0 ? 9'd0 :
             slot_in[15] ? ~{2'b01, slot_in[6:0]} + 9'd1 : {2'b01, slot_in[6:0]}
  };
  assign w_fp_bits = fp_in ? w_fp : '0;
  delay_chain #(.WIDTH(FP_W), .DEPTH(MUL_LAT + 1)) u_fp (
    .clk(clk), .rst_n(rst_n), .clr(1'b0), .d(w_fp_bits), .q(fp_out)
  );
endmodule

// File: rtl/pe_stg_mc.sv
// pe_stg_mc: multi-lane int8 MM / bf16 unpack PE stage with auto tile capture and result drain chain
module pe_stg_mc import pe_pkg::*; #(
  parameter int LANES   = 4,
  parameter int DATA_W  = 8,
  parameter int ACC_W   = 32,
  parameter int MUL_LAT = 2,
  parameter int K_W     = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [1:0]             mode_in,
  input  logic                   valid_in,
  input  logic                   y_sel_in,
  input  logic [K_W-1:0]         k_len_in,
  input  logic                   drain_in,
  input  logic                   clr_in,
  input  logic [DATA_W-1:0]      left_in,
  output logic [DATA_W-1:0]      right_out,
  output logic                   right_valid_out,
  input  logic [LANES*ACC_W-1:0] top_in,
  output logic [LANES*ACC_W-1:0] bottom_out,
  output logic                   res_valid_out,
  output logic [LANES*FP_W-1:0]  fp_out,
  output logic                   fp_valid_out,
  output logic                   sat_out,
  output logic                   ovr_out
);
  localparam int BUS_W = LANES * ACC_W;
  state_e           r_state;
  logic [K_W-1:0]   r_cnt, r_klen, w_cnt_nx, w_k;
  logic             w_mm_v, w_fp_v, w_last, w_ex_v, w_ex_last, w_cap, w_wr, w_ovr;
  logic [1:0]       w_tag_q;
  logic [LANES-1:0] w_sat;
  logic [BUS_W-1:0] w_res, r_res, r_hold, r_bottom;
  logic [DATA_W-1:0] r_right;
  logic             r_right_v, r_hold_v, r_res_v, r_sat, r_ovr;
  assign w_mm_v   = valid_in && mode_in == MODE_MM;
  assign w_fp_v   = valid_in && mode_in == MODE_FPU;
  assign w_k      = r_state == S_IDLE ? (k_len_in == '0 ? K_W'(1) : k_len_in) : r_klen;
  assign w_cnt_nx = r_state == S_IDLE ? K_W'(1) : r_cnt + K_W'(1);
  assign w_last   = w_mm_v && w_cnt_nx == w_k;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_klen  <= '0;
    end else if (clr_in) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_klen  <= '0;
    end else if (w_mm_v) begin
      r_state <= w_last ? S_IDLE : S_ACC;
      r_cnt   <= w_cnt_nx;
      r_klen  <= w_k;
    end
  end
  delay_chain #(.WIDTH(2), .DEPTH(MUL_LAT)) u_tag (
    .clk(clk), .rst_n(rst_n), .clr(clr_in), .d({w_mm_v, w_last}), .q(w_tag_q)
  );
  assign w_ex_v    = w_tag_q[1];
  assign w_ex_last = w_tag_q[0];
  delay_chain #(.WIDTH(1), .DEPTH(MUL_LAT + 1)) u_fpv (
    .clk(clk), .rst_n(rst_n), .clr(1'b0), .d(w_fp_v), .q(fp_valid_out)
  );
  for (genvar l = 0; l < LANES; l++) begin : g_lane
    pe_lane #(.DATA_W(DATA_W), .ACC_W(ACC_W), .MUL_LAT(MUL_LAT)) u_lane (
      .clk(clk), .rst_n(rst_n), .clr_in(clr_in), .mm_in(w_mm_v), .fp_in(w_fp_v),
      .y_sel_in(y_sel_in), .left_in(left_in), .slot_in(top_in[lane_lsb(l, ACC_W) +: 16]),
      .ex_v_in(w_ex_v), .ex_last_in(w_ex_last), .res_out(w_res[lane_lsb(l, ACC_W) +: ACC_W]),
      .sat_out(w_sat[l]), .fp_out(fp_out[lane_lsb(l, FP_W) +: FP_W])
    );
  end
  // a capture colliding with drain parks in r_hold and lands on the next non-drain cycle
  assign w_cap = w_ex_v && w_ex_last && !clr_in;
  assign w_wr  = !drain_in && (w_cap || r_hold_v);
  assign w_ovr = drain_in ? w_cap && r_hold_v : w_wr && (r_res_v || (w_cap && r_hold_v));
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_right   <= '0;
      r_right_v <= 1'b0;
      r_bottom  <= '0;
      r_res     <= '0;
      r_res_v   <= 1'b0;
      r_hold    <= '0;
      r_hold_v  <= 1'b0;
      r_sat     <= 1'b0;
      r_ovr     <= 1'b0;
    end else begin
      r_right   <= left_in;
      r_right_v <= valid_in;
      r_bottom  <= drain_in ? r_res : top_in;
      r_res     <= drain_in ? top_in : w_cap ? w_res : r_hold_v ? r_hold : r_res;
      r_res_v   <= !drain_in && (w_wr || r_res_v);
      r_hold    <= drain_in && w_cap ? w_res : r_hold;
      r_hold_v  <= drain_in && (w_cap || r_hold_v);
      r_sat     <= !clr_in && (r_sat || |w_sat);
      r_ovr     <= !clr_in && (r_ovr || w_ovr);
    end
  end
  assign right_out       = r_right;
  assign right_valid_out = r_right_v;
  assign bottom_out      = drain_in ? r_res : r_bottom;
  assign res_valid_out   = r_res_v;
  assign sat_out         = r_sat;
  assign ovr_out         = r_ovr;
endmodule
